// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the chunk-serial shared-adder controller.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_W      = 16;
  localparam int unsigned DEF_CHUNKS = 4;

  // Full operand width for a given chunk width and chunk count.
  function automatic int unsigned op_w(input int unsigned w, input int unsigned chunks);
    return w * chunks;
  endfunction

  // Chunk counter width; at least one bit even for a single chunk.
  function automatic int unsigned cnt_w(input int unsigned chunks);
    return (chunks > 1) ? int'($clog2(chunks)) : 1;
  endfunction

  localparam int unsigned OP_W  = op_w(DEF_W, DEF_CHUNKS);
  localparam int unsigned CNT_W = cnt_w(DEF_CHUNKS);

endpackage

// File: rtl/rca_nbit.sv
// n-bit ripple-carry adder used as the shared chunk adder.
module rca_nbit #(
  parameter int n = 16
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] s,
  output logic         cout
);

  // Bit-serial carry ripple from LSB to MSB.
  always_comb begin : ripple
    logic carry;
    carry = cin;
    s     = '0;
    for (int unsigned i = 0; i < n; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Two-requester controller sharing one chunk adder for wide chunk-serial additions.
module adder_share_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned CHUNKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [W*CHUNKS-1:0]   req0_x,
  input  logic [W*CHUNKS-1:0]   req0_y,
  input  logic                  req0_cin,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [W*CHUNKS-1:0]   req1_x,
  input  logic [W*CHUNKS-1:0]   req1_y,
  input  logic                  req1_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [W*CHUNKS-1:0]   rsp_s,
  output logic                  rsp_cout
);

  localparam int unsigned OPW = op_w(W, CHUNKS);
  localparam int unsigned CW  = cnt_w(CHUNKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHUNKS - 1);

  state_t           state;
  logic             last;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [OPW-1:0]   x_r;
  logic [OPW-1:0]   y_r;
  logic             grant;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [W-1:0]     add_s;
  logic             add_co;

  // Round-robin grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last;
    else                          grant = req1_valid;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;

  // Select the current chunk of the latched operands for the shared adder.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int unsigned k = 0; k < CHUNKS; k++) begin
      if (cnt == CW'(k)) begin
        add_a = x_r[k*W +: W];
        add_b = y_r[k*W +: W];
      end
    end
  end

  rca_nbit #(.n(W)) u_rca (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .s    (add_s),
    .cout (add_co)
  );

  // Controller FSM: accept, add chunks LSB first, then hold the response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      carry     <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      rsp_valid <= 1'b0;
      rsp_s     <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            x_r    <= grant ? req1_x   : req0_x;
            y_r    <= grant ? req1_y   : req0_y;
            carry  <= grant ? req1_cin : req0_cin;
            rsp_id <= grant;
            last   <= grant;
            cnt    <= '0;
            state  <= ADD;
          end
        end
        ADD: begin
          // Sum chunks land directly in rsp_s; rsp_valid stays low until all are written.
          for (int unsigned k = 0; k < CHUNKS; k++) begin
            if (cnt == CW'(k)) rsp_s[k*W +: W] <= add_s;
          end
          carry <= add_co;
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            rsp_cout  <= add_co;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl with a behavioural sum/arbitration model.
module tb_adder_share_ctrl;

  localparam int unsigned W      = 16;
  localparam int unsigned CHUNKS = 4;
  localparam int unsigned OP_W   = W * CHUNKS;
  localparam int          LAT    = CHUNKS + 1;
  localparam int          PERIOD = CHUNKS + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [OP_W-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic            req0_cin = 1'b0, req1_cin = 1'b0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic            rsp_id;
  logic [OP_W-1:0] rsp_s;
  logic            rsp_cout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit tb_last = 1'b1;

  adder_share_ctrl #(.W(W), .CHUNKS(CHUNKS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_s      (rsp_s),
    .rsp_cout   (rsp_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OP_W-1:0] rnd_op();
    return {$urandom, $urandom};
  endfunction

  // Reference: full-precision sum, overflow bit on top.
  function automatic logic [OP_W:0] ref_sum(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{OP_W{1'b0}}, c};
  endfunction

  // Reference arbitration: lone requester wins, contention alternates away from the last winner.
  function automatic int exp_grant(input bit v0, input bit v1);
    if (v0 && v1) return tb_last ? 0 : 1;
    return v1 ? 1 : 0;
  endfunction

  // Bounded wait for an offered grant (sampled on negedge, accept on the next posedge).
  task automatic wait_grant(output int who, output int t, output bit ok);
    ok = 1'b0; who = -1; t = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) begin who = 2; t = cyc; ok = 1'b1; break; end
      if (req0_ready && req0_valid) begin who = 0; t = cyc; ok = 1'b1; break; end
      if (req1_ready && req1_valid) begin who = 1; t = cyc; ok = 1'b1; break; end
    end
  endtask

  // Bounded wait for rsp_valid.
  task automatic wait_rsp(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin t = cyc; ok = 1'b1; break; end
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tb_last = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_s !== '0) begin errors++; $display("FAIL reset_rsp_s: got %h expected 0", rsp_s); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_rsp_cout: got %b expected 0", rsp_cout); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    release_reset();
  endtask

  task automatic test_single_req0();
    int who, ta, tr; bit ok;
    rsp_ready = 1'b1;
    req0_x = 64'h0000_0000_0000_FFFF; req0_y = 64'h1; req0_cin = 1'b0;
    req0_valid = 1'b1;
    wait_grant(who, ta, ok);
    checks++; if (!ok || who != 0) begin errors++; $display("FAIL single_grant: got %0d expected 0", who); end
    tb_last = 1'b0;
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_rsp(tr, ok);
    checks++; if (!ok || tr - ta != LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", ok ? tr - ta : -1, LAT); end
    checks++; if (rsp_s !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL single_sum: got %h expected 0000000000010000", rsp_s); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL single_cout: got %b expected 0", rsp_cout); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b expected 0", rsp_id); end
  endtask

  task automatic test_carry_chain();
    int who, ta, tr; bit ok;
    req1_x = '1; req1_y = '0; req1_cin = 1'b1;
    req1_valid = 1'b1;
    wait_grant(who, ta, ok);
    checks++; if (!ok || who != 1) begin errors++; $display("FAIL carry_grant: got %0d expected 1", who); end
    tb_last = 1'b1;
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(tr, ok);
    checks++; if (!ok || tr - ta != LAT) begin errors++; $display("FAIL carry_latency: got %0d expected %0d", ok ? tr - ta : -1, LAT); end
    checks++; if (rsp_s !== '0) begin errors++; $display("FAIL carry_sum: got %h expected 0", rsp_s); end
    checks++; if (rsp_cout !== 1'b1) begin errors++; $display("FAIL carry_cout: got %b expected 1", rsp_cout); end
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL carry_id: got %b expected 1", rsp_id); end
  endtask

  task automatic test_round_robin();
    int who, ta, tr, prev_ta, exp;
    bit ok;
    logic [OP_W-1:0] ex, ey; logic ec;
    logic [OP_W:0] es;
    rst_n = 1'b0;
    req0_x = rnd_op(); req0_y = rnd_op(); req0_cin = 1'($urandom);
    req1_x = rnd_op(); req1_y = rnd_op(); req1_cin = 1'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    release_reset();
    prev_ta = 0;
    for (int n = 0; n < 4; n++) begin
      exp = exp_grant(1'b1, 1'b1);
      wait_grant(who, ta, ok);
      checks++; if (!ok || who != exp) begin errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", n, who, exp); end
      if (n > 0) begin
        checks++; if (ta - prev_ta != PERIOD) begin errors++; $display("FAIL rr_period[%0d]: got %0d expected %0d", n, ta - prev_ta, PERIOD); end
      end
      prev_ta = ta;
      tb_last = (who == 1);
      ex = (who == 1) ? req1_x : req0_x;
      ey = (who == 1) ? req1_y : req0_y;
      ec = (who == 1) ? req1_cin : req0_cin;
      es = ref_sum(ex, ey, ec);
      @(posedge clk); #1;
      if (who == 1) begin req1_x = rnd_op(); req1_y = rnd_op(); req1_cin = 1'($urandom); end
      else begin req0_x = rnd_op(); req0_y = rnd_op(); req0_cin = 1'($urandom); end
      wait_rsp(tr, ok);
      checks++; if (!ok || {rsp_cout, rsp_s} !== es) begin errors++; $display("FAIL rr_sum[%0d]: got %h expected %h", n, {rsp_cout, rsp_s}, es); end
      checks++; if (rsp_id !== 1'(who)) begin errors++; $display("FAIL rr_id[%0d]: got %b expected %0d", n, rsp_id, who); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int who, ta, tr; bit ok;
    logic [OP_W:0] es;
    logic [OP_W-1:0] s_hold;
    rsp_ready = 1'b0;
    req0_x = rnd_op(); req0_y = rnd_op(); req0_cin = 1'($urandom);
    es = ref_sum(req0_x, req0_y, req0_cin);
    req0_valid = 1'b1;
    wait_grant(who, ta, ok);
    checks++; if (!ok || who != 0) begin errors++; $display("FAIL bp_grant: got %0d expected 0", who); end
    tb_last = 1'b0;
    @(posedge clk); #1 req0_valid = 1'b0;
    req1_x = rnd_op(); req1_y = rnd_op(); req1_cin = 1'($urandom);
    req1_valid = 1'b1;
    wait_rsp(tr, ok);
    checks++; if (!ok || {rsp_cout, rsp_s} !== es) begin errors++; $display("FAIL bp_sum: got %h expected %h", {rsp_cout, rsp_s}, es); end
    s_hold = es[OP_W-1:0];
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_s !== s_hold) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b s=%h expected valid=1 s=%h", i, rsp_valid, rsp_s, s_hold); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 00", i, {req0_ready, req1_ready}); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_before_take: got %b expected 1", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_taken: got %b expected 0", rsp_valid); end
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL bp_next_grant: got %b expected 01", {req0_ready, req1_ready}); end
    ta = cyc;
    es = ref_sum(req1_x, req1_y, req1_cin);
    tb_last = 1'b1;
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(tr, ok);
    checks++; if (!ok || tr - ta != LAT) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", ok ? tr - ta : -1, LAT); end
    checks++; if ({rsp_cout, rsp_s} !== es || rsp_id !== 1'b1) begin errors++; $display("FAIL bp_second: got %h id %b expected %h id 1", {rsp_cout, rsp_s}, rsp_id, es); end
  endtask

  task automatic test_reset_mid();
    int who, ta, tr, exp; bit ok;
    logic [OP_W:0] es;
    rsp_ready = 1'b1;
    req0_x = rnd_op(); req0_y = rnd_op(); req0_cin = 1'($urandom);
    req1_x = rnd_op(); req1_y = rnd_op(); req1_cin = 1'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp = exp_grant(1'b1, 1'b1);
    wait_grant(who, ta, ok);
    checks++; if (!ok || who != exp) begin errors++; $display("FAIL rm_first_grant: got %0d expected %0d", who, exp); end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_s !== '0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL rm_reset_values: got valid=%b s=%h cout=%b id=%b expected all 0", rsp_valid, rsp_s, rsp_cout, rsp_id);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_rsp[%0d]: got %b expected 0", i, rsp_valid); end
    end
    release_reset();
    exp = exp_grant(1'b1, 1'b1);
    es = ref_sum(req0_x, req0_y, req0_cin);
    wait_grant(who, ta, ok);
    checks++; if (!ok || who != exp || exp != 0) begin errors++; $display("FAIL rm_after_grant: got %0d expected 0", who); end
    tb_last = 1'b0;
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(tr, ok);
    checks++; if (!ok || tr - ta != LAT) begin errors++; $display("FAIL rm_latency: got %0d expected %0d", ok ? tr - ta : -1, LAT); end
    checks++; if ({rsp_cout, rsp_s} !== es || rsp_id !== 1'b0) begin errors++; $display("FAIL rm_sum: got %h id %b expected %h id 0", {rsp_cout, rsp_s}, rsp_id, es); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int who, ta, tr, exp, pat, stall;
    bit ok, v0, v1;
    logic [OP_W:0] es;
    logic [OP_W-1:0] s_hold;
    for (int n = 0; n < 1000 && errors < 20; n++) begin
      pat = int'($urandom_range(0, 2));
      v0 = (pat != 1); v1 = (pat != 0);
      stall = int'($urandom_range(0, 3));
      req0_x = ($urandom_range(0, 7) == 0) ? '1 : rnd_op();
      req0_y = rnd_op(); req0_cin = 1'($urandom);
      req1_x = rnd_op();
      req1_y = ($urandom_range(0, 7) == 0) ? '1 : rnd_op();
      req1_cin = 1'($urandom);
      rsp_ready = (stall == 0);
      req0_valid = v0; req1_valid = v1;
      exp = exp_grant(v0, v1);
      wait_grant(who, ta, ok);
      checks++; if (!ok || who != exp) begin errors++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", n, who, exp); end
      tb_last = (exp == 1);
      es = (exp == 1) ? ref_sum(req1_x, req1_y, req1_cin) : ref_sum(req0_x, req0_y, req0_cin);
      @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      wait_rsp(tr, ok);
      checks++; if (!ok || tr - ta != LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, ok ? tr - ta : -1, LAT); end
      checks++; if ({rsp_cout, rsp_s} !== es) begin errors++; $display("FAIL rand_sum[%0d]: got %h expected %h", n, {rsp_cout, rsp_s}, es); end
      checks++; if (rsp_id !== 1'(exp)) begin errors++; $display("FAIL rand_id[%0d]: got %b expected %0d", n, rsp_id, exp); end
      s_hold = es[OP_W-1:0];
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_s !== s_hold) begin errors++; $display("FAIL rand_hold[%0d]: got valid=%b s=%h expected valid=1 s=%h", n, rsp_valid, rsp_s, s_hold); end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_carry_chain();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
